byte_arbiter: RTL and testbench
===============================

BYTE_ARBITER -- requirements
Module: byte_arbiter

Interface
REQ-001 The block SHALL have parameter PORTS, default 2, meaning the number of requesting byte-bus masters (2..8).
REQ-002 The block SHALL have parameter DATA_BYTE, default 4, meaning the data width in bytes.
REQ-003 The block SHALL have parameter ADDR_SIZE, default 32, meaning the address width.
REQ-004 The block SHALL have port clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_i  in  1  reset, asynchronous and active-high.
REQ-006 The block SHALL have port reqEnable_i  in  1 [PORTS]  request valid per master.
REQ-007 The block SHALL have port reqIsWrite_i  in  1 [PORTS]  request is a write.
REQ-008 The block SHALL have port reqWriteMask_i  in  DATA_BYTE [PORTS]  byte write enables.
REQ-009 The block SHALL have port reqAddr_i  in  ADDR_SIZE [PORTS]  byte address.
REQ-010 The block SHALL have port reqWriteData_i  in  DATA_BYTE*8 [PORTS]  write data.
REQ-011 The block SHALL have port reqReadData_o  out  DATA_BYTE*8 [PORTS]  read data, one cycle after acceptance.
REQ-012 The block SHALL have port reqHold_o  out  1 [PORTS]  request not accepted this cycle; master keeps it stable.
REQ-013 The block SHALL have ports memEnable_o, memIsWrite_o, memWriteMask_o, memAddr_o, memWriteData_o  out  (same widths, scalar)  downstream request, feeding the address demux.
REQ-014 The block SHALL have ports memReadData_i  in  DATA_BYTE*8 and memHold_i  in  1  downstream read data and hold.

Function
REQ-015 A request on port p SHALL be accepted in a cycle iff p is granted, reqEnable_i[p]=1 and memHold_i=0.
REQ-016 Grant SHALL be combinational: if lock_r is set, grant = lockPort_r; otherwise the first enabled port searching upward from ptr_r, wrapping PORTS-1 -> 0.
REQ-017 The granted port's request fields SHALL drive mem*_o unmodified; with no enabled port, memEnable_o, memIsWrite_o, memWriteMask_o, memAddr_o and memWriteData_o SHALL all be 0.
REQ-018 reqHold_o[p] SHALL be 1 when reqEnable_i[p]=1 and (p not granted or memHold_i=1); otherwise 0.
REQ-019 On acceptance of port g, ptr_r SHALL become (g+1) mod PORTS; otherwise ptr_r SHALL hold its value.
REQ-020 When the granted request is held (memEnable_o=1, memHold_i=1), lock_r SHALL be set and lockPort_r SHALL be set to g, so the grant cannot move to another port during a downstream stall.
REQ-021 lock_r SHALL clear on the cycle the locked request is accepted.
REQ-022 If a locked port drops reqEnable_i (protocol violation), lock_r SHALL clear in that cycle and arbitration SHALL resume from ptr_r.
REQ-023 Registers rdValid_r and rdPort_r SHALL capture acceptance and g each cycle; this gives a read-return latency of exactly 1 cycle.
REQ-024 reqReadData_o[rdPort_r] SHALL equal memReadData_i when rdValid_r=1; all other ports, and all ports when rdValid_r=0, SHALL read 0.
REQ-025 Writes SHALL also set rdValid_r, and the returned data SHALL be don't-care to the master.
REQ-026 Back-to-back acceptances SHALL be sustained at 1 per cycle, with no bubble on a grant change.

Reset
REQ-027 While rst_i=1, ptr_r=0, lock_r=0, lockPort_r=0, rdValid_r=0 and rdPort_r=0 SHALL hold, taking effect asynchronously.
REQ-028 During reset, all reqReadData_o SHALL be 0; mem*_o and reqHold_o SHALL follow REQ-016..018 with reset state values.
REQ-029 A request held at reset assertion SHALL be dropped from lock and re-arbitrated from port 0 after reset release.

Verification
REQ-030 Scenario: Port 0 and port 1 both enabled continuously with memHold_i=0 -> grants alternate 0,1,0,1; the loser sees reqHold_o=1 each cycle.
REQ-031 Scenario: Port 1 reads addr 0x1000_0010, memReadData_i=0xCAFEBABE the next cycle -> reqReadData_o[1]=0xCAFEBABE and reqReadData_o[0]=0.
REQ-032 Scenario: Port 0 is granted, memHold_i=1 for 3 cycles, and port 1 is enabled throughout -> mem*_o stays on port 0 for all 4 cycles, and port 1 is granted in cycle 5.
REQ-033 Scenario: Port 0 write, mask 4'b0101, data 0x11223344, addr 0x8000_0004 -> the mem*_o fields match exactly in the same cycle, with reqHold_o[0]=0.
REQ-034 Scenario: rst_i is asserted mid-lock on port 1 -> lock_r=0 immediately, and after release a simultaneous request on ports 0 and 1 grants port 0.
REQ-035 Scenario: PORTS=3 with only port 2 enabled -> it is granted every cycle, ptr_r=0 after each acceptance, and the wrap-around behaves correctly.

Source files
------------

// File: rtl/byte_arbiter.sv
// rtl/byte_arbiter.sv - round-robin byte-bus arbiter with stall lock and 1-cycle read return
// Grants one of PORTS masters onto a single downstream port; a stalled grant stays locked.
module byte_arbiter #(
  parameter int PORTS     = 2,
  parameter int DATA_BYTE = 4,
  parameter int ADDR_SIZE = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [PORTS-1:0]         reqEnable_i,
  input  logic [PORTS-1:0]         reqIsWrite_i,
  input  logic [DATA_BYTE-1:0]     reqWriteMask_i [PORTS],
  input  logic [ADDR_SIZE-1:0]     reqAddr_i      [PORTS],
  input  logic [DATA_BYTE*8-1:0]   reqWriteData_i [PORTS],
  output logic [DATA_BYTE*8-1:0]   reqReadData_o  [PORTS],
  output logic [PORTS-1:0]         reqHold_o,
  output logic                     memEnable_o,
  output logic                     memIsWrite_o,
  output logic [DATA_BYTE-1:0]     memWriteMask_o,
  output logic [ADDR_SIZE-1:0]     memAddr_o,
  output logic [DATA_BYTE*8-1:0]   memWriteData_o,
  input  logic [DATA_BYTE*8-1:0]   memReadData_i,
  input  logic                     memHold_i
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PW-1:0] ptr_r;
  logic          lock_r;
  logic [PW-1:0] lockPort_r;
  logic          rdValid_r;
  logic [PW-1:0] rdPort_r;

  logic          any_grant;
  logic [PW-1:0] grant;
  logic          accept;

  // A lock only holds while its owner still requests; otherwise fall back to the rotating search.
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    any_grant = 1'b0;
    grant     = '0;
    sum       = '0;
    idx       = '0;
    if (lock_r && reqEnable_i[lockPort_r]) begin
      any_grant = 1'b1;
      grant     = lockPort_r;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        sum = {1'b0, ptr_r} + (PW+1)'(i);
        if (sum >= (PW+1)'(PORTS)) sum = sum - (PW+1)'(PORTS);
        idx = sum[PW-1:0];
        if (!any_grant && reqEnable_i[idx]) begin
          any_grant = 1'b1;
          grant     = idx;
        end
      end
    end
  end

  assign accept = any_grant && !memHold_i;

  always_comb begin
    memEnable_o    = any_grant;
    memIsWrite_o   = 1'b0;
    memWriteMask_o = '0;
    memAddr_o      = '0;
    memWriteData_o = '0;
    if (any_grant) begin
      memIsWrite_o   = reqIsWrite_i[grant];
      memWriteMask_o = reqWriteMask_i[grant];
      memAddr_o      = reqAddr_i[grant];
      memWriteData_o = reqWriteData_i[grant];
    end
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      reqHold_o[p]     = reqEnable_i[p] && (!(any_grant && grant == PW'(p)) || memHold_i);
      reqReadData_o[p] = (rdValid_r && rdPort_r == PW'(p)) ? memReadData_i : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_r      <= '0;
      lock_r     <= 1'b0;
      lockPort_r <= '0;
      rdValid_r  <= 1'b0;
      rdPort_r   <= '0;
    end else begin
      rdValid_r <= accept;
      rdPort_r  <= grant;
      if (accept) ptr_r <= (grant == PW'(PORTS-1)) ? '0 : grant + PW'(1);
      lock_r <= any_grant && memHold_i;
      if (any_grant && memHold_i) lockPort_r <= grant;
    end
  end

endmodule

// File: tb/tb_byte_arbiter.sv
// tb/tb_byte_arbiter.sv - scoreboard bench for byte_arbiter (3 ports) with a queue-based reference model
module tb_byte_arbiter;
  localparam int P = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [P-1:0]      en, wr;
  logic [3:0]        mask  [P];
  logic [31:0]       addr  [P];
  logic [31:0]       wdata [P];
  logic [31:0]       rdata [P];
  logic [P-1:0]      hold;
  logic              m_en, m_wr;
  logic [3:0]        m_mask;
  logic [31:0]       m_addr, m_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_hold;

  byte_arbiter #(.PORTS(P), .DATA_BYTE(4), .ADDR_SIZE(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .reqEnable_i(en), .reqIsWrite_i(wr), .reqWriteMask_i(mask),
    .reqAddr_i(addr), .reqWriteData_i(wdata),
    .reqReadData_o(rdata), .reqHold_o(hold),
    .memEnable_o(m_en), .memIsWrite_o(m_wr), .memWriteMask_o(m_mask),
    .memAddr_o(m_addr), .memWriteData_o(m_wdata),
    .memReadData_i(mem_rdata), .memHold_i(mem_hold)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             en;
    logic             wr;
    logic [3:0]       mask;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [P-1:0]     hold;
    logic [P-1:0][31:0] rd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;

  // Reference state: rotation start, locked owner (-1 none), port owed read data next cycle (-1 none)
  int m_ptr = 0;
  int m_lock = -1;
  int m_rd = -1;
  logic [P-1:0] pred_hold = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_lock = -1; m_rd = -1; pred_hold = '0;
  endtask

  task automatic push_expected();
    int g;
    int order[$];
    exp_t e;
    g = -1;
    if (m_lock >= 0 && en[m_lock]) g = m_lock;
    else begin
      for (int k = 0; k < P; k++) order.push_back((m_ptr + k) % P);
      foreach (order[j]) if (g < 0 && en[order[j]]) g = order[j];
    end
    e = '0;
    if (g >= 0) begin
      e.en = 1'b1; e.wr = wr[g]; e.mask = mask[g]; e.addr = addr[g]; e.wdata = wdata[g];
    end
    for (int p = 0; p < P; p++) begin
      e.hold[p] = en[p] && (p != g || mem_hold);
      if (m_rd == p) e.rd[p] = mem_rdata;
    end
    q.push_back(e);
    pred_hold = e.hold;
    if (g >= 0 && !mem_hold) begin
      m_rd = g;
      m_ptr = (g + 1) % P;
    end else m_rd = -1;
    m_lock = (g >= 0 && mem_hold) ? g : -1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mem_enable", m_en, e.en);
        chk("mem_is_write", m_wr, e.wr);
        chk("mem_mask", m_mask, e.mask);
        chk("mem_addr", m_addr, e.addr);
        chk("mem_wdata", m_wdata, e.wdata);
        chk("req_hold", hold, e.hold);
        for (int p = 0; p < P; p++) chk($sformatf("rdata%0d", p), rdata[p], e.rd[p]);
      end
    end
  end

  task automatic tick();
    push_expected();
    @(negedge clk);
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    en = '0; wr = '0; mem_hold = 1'b0; mem_rdata = '0;
    for (int p = 0; p < P; p++) begin
      mask[p] = '0; wdata[p] = '0; addr[p] = 32'hA000_0000 + 32'(p * 16);
    end
  endtask

  initial begin
    clear();
    // Reset state: grant search from port 0, no read return
    en = 3'b100;
    #1;
    chk("rst_mem_en", m_en, 1'b1);
    chk("rst_addr", m_addr, addr[2]);
    chk("rst_hold", hold, 3'b000);
    for (int p = 0; p < P; p++) chk("rst_rdata", rdata[p], 32'h0);
    adv();
    rst = 1'b0;
    model_reset();
    clear();

    // Port 0 write passes through in the same cycle
    en = 3'b001; wr[0] = 1'b1; mask[0] = 4'b0101; wdata[0] = 32'h1122_3344; addr[0] = 32'h8000_0004;
    tick();
    chk("s033_addr", m_addr, 32'h8000_0004);
    chk("s033_mask", m_mask, 4'b0101);
    chk("s033_wdata", m_wdata, 32'h1122_3344);
    chk("s033_wr", m_wr, 1'b1);
    chk("s033_hold", hold, 3'b000);
    adv();

    // Port 1 read, data returned one cycle later
    clear();
    en = 3'b010; addr[1] = 32'h1000_0010;
    tick();
    chk("s031_addr", m_addr, 32'h1000_0010);
    adv();
    en = '0; mem_rdata = 32'hCAFE_BABE;
    tick();
    chk("s031_rd1", rdata[1], 32'hCAFE_BABE);
    chk("s031_rd0", rdata[0], 32'h0);
    adv();

    // Two continuous requesters alternate (rotation currently at 2)
    clear();
    en = 3'b011;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s030_addr", m_addr, addr[i % 2]);
      chk("s030_hold", hold, (i % 2 == 0) ? 3'b010 : 3'b001);
      adv();
    end

    // Lone port 2 granted every cycle; rotation wraps to 0
    en = 3'b100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s035_addr", m_addr, addr[2]);
      chk("s035_hold", hold, 3'b000);
      adv();
    end
    en = 3'b111;
    tick();
    chk("s035_wrap", m_addr, addr[0]);
    adv();
    en = 3'b100;
    tick();
    adv();

    // Downstream stall keeps port 0 for 4 cycles, then port 1
    en = 3'b011; mem_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_hold = 1'b0;
      tick();
      chk("s032_addr", m_addr, addr[0]);
      chk("s032_hold", hold, (i == 3) ? 3'b010 : 3'b011);
      adv();
    end
    tick();
    chk("s032_next", m_addr, addr[1]);
    adv();

    // Lock on port 1 while rotation points at 2, then reset mid-lock
    clear();
    en = 3'b010;
    tick(); adv();
    mem_hold = 1'b1;
    tick(); adv();
    en = 3'b011;
    tick();
    chk("s034_locked", m_addr, addr[1]);
    rst = 1'b1; mem_hold = 1'b0;
    #1;
    chk("s034_rst_addr", m_addr, addr[0]);
    chk("s034_rst_hold", hold, 3'b010);
    adv();
    rst = 1'b0;
    model_reset();
    tick();
    chk("s034_after", m_addr, addr[0]);
    adv();

    // Randomized traffic; held masters keep their request stable
    clear();
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < P; p++) begin
        if (!pred_hold[p]) begin
          en[p] = ($urandom_range(0, 99) < 55);
          wr[p] = 1'($urandom);
          mask[p] = 4'($urandom);
          addr[p] = $urandom;
          wdata[p] = $urandom;
        end
      end
      mem_hold = ($urandom_range(0, 99) < 30);
      mem_rdata = $urandom;
      tick();
      adv();
    end

    clear();
    tick();
    adv();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
